// File: rtl/fetch_if.sv
// Fetch-stage bundle: byte-wide instruction memory port, decode handshake and redirect.
interface fetch_if #(
  parameter int PC_WIDTH = 32
) ();
  logic                imem_rd_en;
  logic [PC_WIDTH-1:0] imem_addr;
  logic [7:0]          imem_rdata;
  logic                out_valid;
  logic                out_ready;
  logic [PC_WIDTH-1:0] pc;
  logic [31:0]         fetch_instruction;
  logic                fetch_complete;
  logic                redirect_valid;
  logic [PC_WIDTH-1:0] redirect_pc;

  modport master (
    output imem_rd_en, imem_addr, out_valid, pc, fetch_instruction, fetch_complete,
    input  imem_rdata, out_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_rd_en, imem_addr, out_valid, pc, fetch_instruction, fetch_complete,
    output imem_rdata, out_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_unit.sv
// Byte-serial instruction fetch: assembles little-endian words into a 2-entry FIFO for decode.
// state   | meaning
// FETCH   | issue byte reads fptr+0..3, latch returning bytes
// CAPTURE | byte 3 arrives; push word or stop on zero word / memory bound
// STALL   | FIFO full, wait for a slot
// DONE    | fetch finished, FIFO keeps draining
module fetch_unit #(
  parameter int                  PC_WIDTH  = 32,
  parameter int                  MEM_BYTES = 1024,
  parameter logic [PC_WIDTH-1:0] RESET_PC  = '0
) (
  input logic      clk,
  input logic      reset,
  fetch_if.master  bus
);

  typedef enum logic [1:0] {FETCH, CAPTURE, STALL, DONE} state_t;

  localparam logic [PC_WIDTH:0] MEM_LIMIT = (PC_WIDTH+1)'(MEM_BYTES);

  state_t              state, state_next;
  logic [PC_WIDTH-1:0] fptr;
  logic [1:0]          byte_idx;
  logic [23:0]         held;
  logic [PC_WIDTH-1:0] fifo_pc [2];
  logic [31:0]         fifo_word [2];
  logic                rd_ptr, wr_ptr;
  logic [1:0]          count;

  logic [31:0]         word;
  logic                push, pop;
  logic [1:0]          count_after;
  logic [PC_WIDTH:0]   fptr_plus4;
  logic [PC_WIDTH-1:0] redirect_aligned;
  logic                redirect_oob;

  assign word             = {bus.imem_rdata, held};
  assign push             = (state == CAPTURE) && (word != 32'h0);
  assign pop              = (count != 2'd0) && bus.out_ready;
  assign count_after      = count + {1'b0, push} - {1'b0, pop};
  // Extra bit keeps the bound check honest when fptr is near the top of the address space.
  assign fptr_plus4       = {1'b0, fptr} + (PC_WIDTH+1)'(4);
  assign redirect_aligned = bus.redirect_pc & ~PC_WIDTH'(3);
  assign redirect_oob     = {1'b0, redirect_aligned} >= MEM_LIMIT;

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (bus.redirect_valid) begin
      state_next = redirect_oob ? DONE : FETCH;
    end else begin
      case (state)
        FETCH:   if (byte_idx == 2'd3) state_next = CAPTURE;
        CAPTURE: begin
          if (word == 32'h0 || fptr_plus4 >= MEM_LIMIT) state_next = DONE;
          else if (count_after < 2'd2)                  state_next = FETCH;
          else                                          state_next = STALL;
        end
        STALL:   if (count < 2'd2) state_next = FETCH;
        default: state_next = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fptr         <= RESET_PC;
      byte_idx     <= 2'd0;
      held         <= '0;
      rd_ptr       <= 1'b0;
      wr_ptr       <= 1'b0;
      count        <= 2'd0;
      fifo_pc[0]   <= '0;
      fifo_pc[1]   <= '0;
      fifo_word[0] <= '0;
      fifo_word[1] <= '0;
    end else if (bus.redirect_valid) begin
      fptr     <= redirect_aligned;
      byte_idx <= 2'd0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      count    <= 2'd0;
    end else begin
      if (state == FETCH) begin
        byte_idx <= byte_idx + 2'd1;
        // Data for the previous byte request lands now.
        case (byte_idx)
          2'd1:    held[7:0]   <= bus.imem_rdata;
          2'd2:    held[15:8]  <= bus.imem_rdata;
          2'd3:    held[23:16] <= bus.imem_rdata;
          default: ;
        endcase
      end
      if (push) begin
        fifo_pc[wr_ptr]   <= fptr;
        fifo_word[wr_ptr] <= word;
        wr_ptr            <= ~wr_ptr;
        fptr              <= fptr + PC_WIDTH'(4);
      end
      if (pop) rd_ptr <= ~rd_ptr;
      count <= count_after;
    end
  end

  always_comb begin
    bus.imem_rd_en        = !reset && (state == FETCH);
    bus.imem_addr         = bus.imem_rd_en ? fptr + PC_WIDTH'(byte_idx) : '0;
    bus.out_valid         = count != 2'd0;
    bus.pc                = bus.out_valid ? fifo_pc[rd_ptr] : '0;
    bus.fetch_instruction = bus.out_valid ? fifo_word[rd_ptr] : 32'h0;
    bus.fetch_complete    = state == DONE;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-cycle vector table plus hand sequences for stall, bound, redirect and reset.
module tb_fetch_unit;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fetch_if #(.PC_WIDTH(32)) bus ();
  fetch_if #(.PC_WIDTH(32)) bus8 ();

  fetch_unit #(.PC_WIDTH(32), .MEM_BYTES(1024), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .bus(bus));
  fetch_unit #(.PC_WIDTH(32), .MEM_BYTES(8), .RESET_PC(32'h0)) dut8 (
    .clk(clk), .reset(reset), .bus(bus8));

  logic [7:0] mem [0:1023];

  always @(posedge clk) begin
    bus.imem_rdata  <= bus.imem_rd_en  ? mem[bus.imem_addr[9:0]]  : 8'h00;
    bus8.imem_rdata <= bus8.imem_rd_en ? mem[bus8.imem_addr[9:0]] : 8'h00;
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
  endtask

  task automatic load_word(input int a, input logic [31:0] w);
    mem[a]   = w[7:0];
    mem[a+1] = w[15:8];
    mem[a+2] = w[23:16];
    mem[a+3] = w[31:24];
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Leaves time at posedge+1 of cycle 0.
  task automatic do_reset();
    reset = 1'b1;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  typedef struct {
    logic        out_ready;
    logic        e_rd;
    logic [31:0] e_addr;
    logic        e_ov;
    logic [31:0] e_pc;
    logic [31:0] e_ins;
    logic        e_done;
  } vec_t;

  vec_t tv [12];
  logic [31:0] got_pc [$];
  logic [31:0] got_ins [$];
  int first_done;
  logic saw_high;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus8.out_ready      = 1'b1;
    bus8.redirect_valid = 1'b0;
    bus8.redirect_pc    = '0;

    // Single word then terminator, one vector per cycle from cycle 0.
    tv[0]  = '{1'b1, 1'b1, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0};
    tv[1]  = '{1'b1, 1'b1, 32'h1, 1'b0, 32'h0, 32'h0, 1'b0};
    tv[2]  = '{1'b1, 1'b1, 32'h2, 1'b0, 32'h0, 32'h0, 1'b0};
    tv[3]  = '{1'b1, 1'b1, 32'h3, 1'b0, 32'h0, 32'h0, 1'b0};
    tv[4]  = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0};
    tv[5]  = '{1'b1, 1'b1, 32'h4, 1'b1, 32'h0, 32'h00A00513, 1'b0};
    tv[6]  = '{1'b1, 1'b1, 32'h5, 1'b0, 32'h0, 32'h0, 1'b0};
    tv[7]  = '{1'b1, 1'b1, 32'h6, 1'b0, 32'h0, 32'h0, 1'b0};
    tv[8]  = '{1'b1, 1'b1, 32'h7, 1'b0, 32'h0, 32'h0, 1'b0};
    tv[9]  = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0};
    tv[10] = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1};
    tv[11] = '{1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b1};

    clear_mem();
    load_word(0, 32'h00A00513);

    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_rd_en", {31'b0, bus.imem_rd_en}, 32'h0);
    chk("reset_addr", bus.imem_addr, 32'h0);
    chk("reset_out_valid", {31'b0, bus.out_valid}, 32'h0);
    chk("reset_pc", bus.pc, 32'h0);
    chk("reset_instr", bus.fetch_instruction, 32'h0);
    chk("reset_complete", {31'b0, bus.fetch_complete}, 32'h0);

    do_reset();
    for (int i = 0; i < 12; i++) begin
      bus.out_ready = tv[i].out_ready;
      @(negedge clk);
      chk($sformatf("t1_c%0d_rd_en", i), {31'b0, bus.imem_rd_en}, {31'b0, tv[i].e_rd});
      chk($sformatf("t1_c%0d_addr", i), bus.imem_addr, tv[i].e_addr);
      chk($sformatf("t1_c%0d_valid", i), {31'b0, bus.out_valid}, {31'b0, tv[i].e_ov});
      chk($sformatf("t1_c%0d_pc", i), bus.pc, tv[i].e_pc);
      chk($sformatf("t1_c%0d_instr", i), bus.fetch_instruction, tv[i].e_ins);
      chk($sformatf("t1_c%0d_complete", i), {31'b0, bus.fetch_complete}, {31'b0, tv[i].e_done});
      @(posedge clk);
      #1;
    end

    // Back-pressure: two entries buffer, then drain in order.
    clear_mem();
    load_word(0, 32'h00100093);
    load_word(4, 32'h00200113);
    load_word(8, 32'h00300193);
    bus.out_ready = 1'b0;
    do_reset();
    step(12);
    @(negedge clk);
    chk("stall_rd_en", {31'b0, bus.imem_rd_en}, 32'h0);
    chk("stall_valid", {31'b0, bus.out_valid}, 32'h1);
    chk("stall_head_pc", bus.pc, 32'h0);
    bus.out_ready = 1'b1;
    got_pc.delete();
    got_ins.delete();
    for (int k = 0; k < 80; k++) begin
      if (bus.out_valid) begin
        got_pc.push_back(bus.pc);
        got_ins.push_back(bus.fetch_instruction);
      end
      if (bus.fetch_complete && !bus.out_valid) break;
      @(negedge clk);
    end
    chk("drain_count", got_pc.size(), 32'd3);
    for (int k = 0; k < 3; k++) begin
      if (k < got_pc.size()) begin
        chk($sformatf("drain_pc%0d", k), got_pc[k], 32'(4 * k));
        chk($sformatf("drain_ins%0d", k), got_ins[k], 32'h00100093 + 32'(k) * 32'h00100080);
      end
    end
    chk("drain_complete", {31'b0, bus.fetch_complete}, 32'h1);

    // MEM_BYTES=8 instance: two words, then stop at the bound.
    do_reset();
    got_pc.delete();
    got_ins.delete();
    first_done = -1;
    saw_high = 1'b0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (bus8.imem_rd_en && bus8.imem_addr >= 32'h8) saw_high = 1'b1;
      if (bus8.out_valid) begin
        got_pc.push_back(bus8.pc);
        got_ins.push_back(bus8.fetch_instruction);
      end
      if (bus8.fetch_complete && first_done < 0) first_done = c;
    end
    chk("bound_count", got_pc.size(), 32'd2);
    if (got_pc.size() >= 2) begin
      chk("bound_pc0", got_pc[0], 32'h0);
      chk("bound_ins0", got_ins[0], 32'h00100093);
      chk("bound_pc1", got_pc[1], 32'h4);
      chk("bound_ins1", got_ins[1], 32'h00200113);
    end
    chk("bound_done_cycle", 32'(first_done), 32'd10);
    chk("bound_no_high_addr", {31'b0, saw_high}, 32'h0);

    // Redirect during byte_idx 2 of the word at 0x4.
    clear_mem();
    load_word(0, 32'h00100093);
    load_word(4, 32'h00200113);
    load_word(16, 32'h00500293);
    bus.out_ready = 1'b0;
    do_reset();
    step(7);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h11;
    @(negedge clk);
    chk("redir_pre_addr", bus.imem_addr, 32'h6);
    chk("redir_pre_valid", {31'b0, bus.out_valid}, 32'h1);
    @(posedge clk);
    #1;
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    chk("redir_valid", {31'b0, bus.out_valid}, 32'h0);
    chk("redir_rd_en", {31'b0, bus.imem_rd_en}, 32'h1);
    chk("redir_addr", bus.imem_addr, 32'h10);
    bus.out_ready = 1'b1;
    got_pc.delete();
    got_ins.delete();
    for (int k = 0; k < 40; k++) begin
      if (bus.out_valid) begin
        got_pc.push_back(bus.pc);
        got_ins.push_back(bus.fetch_instruction);
      end
      if (bus.fetch_complete && !bus.out_valid) break;
      @(negedge clk);
    end
    chk("redir_count", got_pc.size(), 32'd1);
    if (got_pc.size() >= 1) begin
      chk("redir_pc", got_pc[0], 32'h10);
      chk("redir_ins", got_ins[0], 32'h00500293);
    end

    // Reset mid-word with one entry buffered.
    bus.out_ready = 1'b0;
    do_reset();
    step(7);
    reset = 1'b1;
    @(negedge clk);
    chk("midrst_rd_en", {31'b0, bus.imem_rd_en}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_valid", {31'b0, bus.out_valid}, 32'h0);
    chk("midrst_complete", {31'b0, bus.fetch_complete}, 32'h0);
    chk("midrst_addr", bus.imem_addr, 32'h0);
    chk("midrst_rd_en_c0", {31'b0, bus.imem_rd_en}, 32'h1);
    step(5);
    @(negedge clk);
    chk("midrst_c5_valid", {31'b0, bus.out_valid}, 32'h1);
    chk("midrst_c5_ins", bus.fetch_instruction, 32'h00100093);

    // Redirect beyond the memory bound, then back into range.
    bus.out_ready = 1'b1;
    do_reset();
    step(2);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h400;
    step(1);
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    chk("oob_complete", {31'b0, bus.fetch_complete}, 32'h1);
    chk("oob_rd_en", {31'b0, bus.imem_rd_en}, 32'h0);
    step(3);
    @(negedge clk);
    chk("oob_rd_en_later", {31'b0, bus.imem_rd_en}, 32'h0);
    @(posedge clk);
    #1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h2;
    step(1);
    bus.redirect_valid = 1'b0;
    @(negedge clk);
    chk("reentry_complete", {31'b0, bus.fetch_complete}, 32'h0);
    chk("reentry_addr", bus.imem_addr, 32'h0);
    chk("reentry_rd_en", {31'b0, bus.imem_rd_en}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
